lock_entry_ctrl: RTL and testbench

Front-end controller that drives the `digital_lock` passcode interface from a keypad. It accepts one 4-bit code per keypad strobe and presents it to the lock with a single-cycle `enter` pulse. It then samples `lock_status` after a fixed settle window and reports pass/fail. It counts consecutive failures and enforces a timed lockout during which keypad input is dropped.

---
 rtl/lock_pkg.sv | 25 ++
 rtl/lockout_timer.sv | 40 ++++
 rtl/lock_entry_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lock_entry_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared types and constants for the keypad-to-lock entry controller.
//   LOCK_CODE_W          width of a keypad / passcode code
//   DEF_MAX_FAILS        default consecutive failures before lockout
//   DEF_LOCKOUT_CYCLES   default lockout duration in clk cycles
//   DEF_RESP_WAIT        default cycles from enter falling to lock_status sample
//   lock_entry_state_t   controller FSM states
// -----------------------------------------------------------------------------
package lock_pkg;

  localparam int LOCK_CODE_W        = 4;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 1000;
  localparam int DEF_RESP_WAIT      = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    WAIT    = 3'd2,
    REPORT  = 3'd3,
    LOCKOUT = 3'd4
  } lock_entry_state_t;

endpackage : lock_pkg

// File: rtl/lockout_timer.sv
// -----------------------------------------------------------------------------
// lockout_timer
// Loadable down-counter. A load pulse presets the counter to i_count; it then
// decrements once per cycle and stops at zero. o_done is high for the single
// cycle in which the counter holds 1, i.e. the last cycle of the interval, so
// a load of N yields an interval of exactly N cycles ending with o_done.
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   i_load    preset the counter this cycle
//   i_count   value to preset (interval length in cycles, >= 1)
//   o_done    one-cycle pulse on the final cycle of the interval
// -----------------------------------------------------------------------------
module lockout_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_count,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_count;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == W'(1));

endmodule : lockout_timer

// File: rtl/lock_entry_ctrl.sv
// -----------------------------------------------------------------------------
// lock_entry_ctrl
// Keypad front end for the digital_lock passcode interface. A keypad strobe in
// IDLE latches the code, a one-cycle enter pulse submits it, lock_status is
// sampled RESP_WAIT cycles after enter falls, and a one-cycle result is
// reported. MAX_FAILS consecutive failures trigger a LOCKOUT_CYCLES lockout
// during which keypad strobes are dropped.
//
// Optional feature macro: LOCK_ENTRY_SCRUB_EN
//   defined   : passcode_input is cleared on the edge leaving REPORT
//   undefined : passcode_input keeps the last submitted code
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous, active-high
//   key_bits        keypad code, valid with key_strobe
//   key_strobe      one-cycle keypad event (honoured only in IDLE)
//   passcode_input  code presented to the lock
//   enter           one-cycle submit pulse to the lock (DRIVE)
//   lock_status     lock output, 1 = open
//   busy            high in every state except IDLE
//   result_valid    one-cycle pulse (REPORT), qualifies result_ok
//   result_ok       1 = lock opened on this attempt
//   locked_out      high throughout LOCKOUT
//   fail_count      consecutive failures so far
// -----------------------------------------------------------------------------
module lock_entry_ctrl
  import lock_pkg::*;
#(
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int RESP_WAIT      = DEF_RESP_WAIT,
  localparam int FCW           = $clog2(MAX_FAILS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LOCK_CODE_W-1:0] key_bits,
  input  logic                   key_strobe,
  output logic [LOCK_CODE_W-1:0] passcode_input,
  output logic                   enter,
  input  logic                   lock_status,
  output logic                   busy,
  output logic                   result_valid,
  output logic                   result_ok,
  output logic                   locked_out,
  output logic [FCW-1:0]         fail_count
);

  localparam int WCW = $clog2(RESP_WAIT + 1);
  localparam int LCW = $clog2(LOCKOUT_CYCLES + 1);

  lock_entry_state_t r_state;
  lock_entry_state_t w_next;

  logic [LOCK_CODE_W-1:0] r_passcode;
  logic [WCW-1:0]         r_wait_cnt;
  logic                   r_result_ok;
  logic [FCW-1:0]         r_fail_count;

  logic w_wait_last;
  logic w_lock_load;
  logic w_lock_done;

  // Last WAIT cycle: the counter was loaded with RESP_WAIT on leaving DRIVE.
  assign w_wait_last = (r_state == WAIT) && (r_wait_cnt == WCW'(1));
  assign w_lock_load = (r_state == REPORT) && (w_next == LOCKOUT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (key_strobe) w_next = DRIVE;
      DRIVE:   w_next = WAIT;
      WAIT:    if (w_wait_last) w_next = REPORT;
      // fail_count was already updated when REPORT was entered; a success
      // clears it, so reaching MAX_FAILS here always means a failed attempt.
      REPORT:  w_next = (r_fail_count == FCW'(MAX_FAILS)) ? LOCKOUT : IDLE;
      LOCKOUT: if (w_lock_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (decoded from state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    enter        = 1'b0;
    result_valid = 1'b0;
    locked_out   = 1'b0;
    busy         = (r_state != IDLE);
    unique case (r_state)
      DRIVE:   enter        = 1'b1;
      REPORT:  result_valid = 1'b1;
      LOCKOUT: locked_out   = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched code, response wait counter, result and failure count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_passcode   <= '0;
      r_wait_cnt   <= '0;
      r_result_ok  <= 1'b0;
      r_fail_count <= '0;
    end else begin
      if ((r_state == IDLE) && key_strobe) begin
        r_passcode <= key_bits;
      end
`ifdef LOCK_ENTRY_SCRUB_EN
      // Do not leave the submitted code on the bus once the attempt is over.
      if (r_state == REPORT) begin
        r_passcode <= '0;
      end
`endif

      if (r_state == DRIVE) begin
        r_wait_cnt <= WCW'(RESP_WAIT);
      end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - WCW'(1);
      end

      // Result and failure count update together on entry to REPORT, so the
      // new fail_count is visible alongside result_valid.
      if (w_wait_last) begin
        r_result_ok <= lock_status;
        if (lock_status) begin
          r_fail_count <= '0;
        end else if (r_fail_count != FCW'(MAX_FAILS)) begin
          r_fail_count <= r_fail_count + FCW'(1);
        end
      end

      if ((r_state == LOCKOUT) && w_lock_done) begin
        r_fail_count <= '0;
      end
    end
  end

  lockout_timer #(
    .W (LCW)
  ) u_lockout_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_lock_load),
    .i_count (LCW'(LOCKOUT_CYCLES)),
    .o_done  (w_lock_done)
  );

  assign passcode_input = r_passcode;
  assign result_ok      = r_result_ok;
  assign fail_count     = r_fail_count;

endmodule : lock_entry_ctrl

// File: tb/tb_lock_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lock_entry_ctrl
// Directed self-checking bench for lock_entry_ctrl with MAX_FAILS=3,
// LOCKOUT_CYCLES=12, RESP_WAIT=2. The lock model opens only for code 1010,
// latching its decision on each enter pulse. Outputs are sampled 1 time unit
// after the rising edge; inputs change at the same point.
// -----------------------------------------------------------------------------
module tb_lock_entry_ctrl;
  import lock_pkg::*;

  localparam int MF  = 3;
  localparam int LC  = 12;
  localparam int RW  = 2;
  localparam int FCW = $clog2(MF + 1);
`ifdef LOCK_ENTRY_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic                   clk;
  logic                   reset;
  logic [LOCK_CODE_W-1:0] key_bits;
  logic                   key_strobe;
  logic [LOCK_CODE_W-1:0] passcode_input;
  logic                   enter;
  logic                   lock_status;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ok;
  logic                   locked_out;
  logic [FCW-1:0]         fail_count;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_enter = 0;
  int n_rv    = 0;

  lock_entry_ctrl #(
    .MAX_FAILS      (MF),
    .LOCKOUT_CYCLES (LC),
    .RESP_WAIT      (RW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_bits       (key_bits),
    .key_strobe     (key_strobe),
    .passcode_input (passcode_input),
    .enter          (enter),
    .lock_status    (lock_status),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_ok      (result_ok),
    .locked_out     (locked_out),
    .fail_count     (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lock model: decides open/closed when the code is submitted.
  always @(posedge clk) begin
    if (reset) lock_status <= 1'b0;
    else if (enter) lock_status <= (passcode_input == 4'b1010);
  end

  // Pulse counters used to prove one enter / one result per accepted strobe.
  always @(posedge clk) begin
    if (enter === 1'b1) n_enter++;
    if (result_valid === 1'b1) n_rv++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_code"},   32'(passcode_input), 32'h0);
    check({tag, "_enter"},  32'(enter),          32'h0);
    check({tag, "_busy"},   32'(busy),           32'h0);
    check({tag, "_rv"},     32'(result_valid),   32'h0);
    check({tag, "_ok"},     32'(result_ok),      32'h0);
    check({tag, "_lo"},     32'(locked_out),     32'h0);
    check({tag, "_fc"},     32'(fail_count),     32'h0);
  endtask

  // One full attempt starting from IDLE; ends in the cycle after REPORT.
  task automatic attempt(input logic [3:0] code, input logic exp_ok, input int exp_fc);
    int e0;
    int r0;
    e0 = n_enter;
    r0 = n_rv;
    key_bits   = code;
    key_strobe = 1'b1;
    tick();                                   // E0: now DRIVE
    key_strobe = 1'b0;
    check("drive_enter", 32'(enter), 32'h1);
    check("drive_code",  32'(passcode_input), 32'(code));
    check("drive_busy",  32'(busy), 32'h1);
    tick();                                   // E1: first WAIT cycle
    check("wait_enter",  32'(enter), 32'h0);
    check("wait_rv",     32'(result_valid), 32'h0);
    repeat (RW - 1) tick();
    check("wait_last_rv", 32'(result_valid), 32'h0);
    tick();                                   // E(1+RW): REPORT
    check("rep_rv",   32'(result_valid), 32'h1);
    check("rep_ok",   32'(result_ok), 32'(exp_ok));
    check("rep_fc",   32'(fail_count), 32'(exp_fc));
    check("rep_code", 32'(passcode_input), 32'(code));
    check("rep_lo",   32'(locked_out), 32'h0);
    tick();                                   // E(2+RW): after REPORT
    check("post_rv",   32'(result_valid), 32'h0);
    check("post_code", 32'(passcode_input), SCRUB ? 32'h0 : 32'(code));
    check("n_enter",   32'(n_enter - e0), 32'h1);
    check("n_rv",      32'(n_rv - r0), 32'h1);
  endtask

  initial begin
    int cnt;
    int e0;
    int r0;

    reset      = 1'b1;
    key_bits   = '0;
    key_strobe = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();
    check_reset_values("idle");

    // 1: correct code opens the lock
    attempt(4'b1010, 1'b1, 0);
    check("t1_busy", 32'(busy), 32'h0);

    // 2: two wrong codes, strobed back to back from the first IDLE cycle
    attempt(4'b1001, 1'b0, 1);
    check("t2_lo1", 32'(locked_out), 32'h0);
    attempt(4'b0000, 1'b0, 2);
    check("t2_lo2", 32'(locked_out), 32'h0);

    // 3: third failure enters lockout; strobes are dropped throughout
    attempt(4'b0011, 1'b0, 3);
    check("t3_lo",   32'(locked_out), 32'h1);
    check("t3_busy", 32'(busy), 32'h1);
    check("t3_fc",   32'(fail_count), 32'h3);
    e0         = n_enter;
    key_bits   = 4'b1010;
    key_strobe = 1'b1;
    cnt        = 0;
    while (locked_out === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    key_strobe = 1'b0;
    check("t3_lockout_len",   32'(cnt), 32'(LC));
    check("t3_lockout_enter", 32'(n_enter - e0), 32'h0);
    check("t3_fc_clear",      32'(fail_count), 32'h0);
    check("t3_idle_busy",     32'(busy), 32'h0);
    tick();
    check("t3_no_late_accept", 32'(busy), 32'h0);

    // 4: strobe while busy is ignored
    e0         = n_enter;
    r0         = n_rv;
    key_bits   = 4'b1010;
    key_strobe = 1'b1;
    tick();                                   // DRIVE
    key_strobe = 1'b0;
    tick();                                   // WAIT
    key_bits   = 4'b0101;
    key_strobe = 1'b1;
    tick();                                   // still WAIT
    key_strobe = 1'b0;
    check("t4_code_held", 32'(passcode_input), 32'hA);
    tick();                                   // REPORT
    check("t4_rv", 32'(result_valid), 32'h1);
    check("t4_ok", 32'(result_ok), 32'h1);
    repeat (4) tick();
    check("t4_n_enter", 32'(n_enter - e0), 32'h1);
    check("t4_n_rv",    32'(n_rv - r0), 32'h1);
    check("t4_busy",    32'(busy), 32'h0);

    // 5: reset during WAIT aborts and clears fail_count
    attempt(4'b0101, 1'b0, 1);
    key_bits   = 4'b1010;
    key_strobe = 1'b1;
    tick();                                   // DRIVE
    key_strobe = 1'b0;
    tick();                                   // WAIT
    r0    = n_rv;
    reset = 1'b1;
    tick();
    check_reset_values("t5_rst");
    reset = 1'b0;
    repeat (4) tick();
    check("t5_no_rv", 32'(n_rv - r0), 32'h0);
    check("t5_busy",  32'(busy), 32'h0);

    // reset while DRIVE is active drops enter on the next edge
    key_bits   = 4'b0110;
    key_strobe = 1'b1;
    tick();                                   // DRIVE
    key_strobe = 1'b0;
    check("t5_drive_enter", 32'(enter), 32'h1);
    reset = 1'b1;
    tick();
    check_reset_values("t5_drv_rst");
    reset = 1'b0;
    tick();

    // normal operation after reset
    attempt(4'b1010, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_lock_entry_ctrl
